hazard_seq: RTL and testbench
=============================

HAZARD_SEQ -- requirements
Module: hazard_seq

Interface
REQ-001 Parameter REG_ADDR_W, default 3: register-address width.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1-15: cycles flush_ifid stays high per taken branch.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ex_mem_read  in  1  instruction in EX is a load.
REQ-006 ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
REQ-007 id_rs1, id_rs2  in  REG_ADDR_W each  source registers of the instruction in ID.
REQ-008 id_rs1_used, id_rs2_used  in  1 each  source actually read.
REQ-009 branch_taken  in  1  branch resolved taken in EX (single-cycle pulse).
REQ-010 mem_req, mem_ack  in  1 each  MEM-stage access request / completion.
REQ-011 pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage register enables.
REQ-012 flush_ifid  out  1  load NOP into IF/ID.
REQ-013 idex_bubble  out  1  force the 23-bit control word into ID/EX to zero.
REQ-014 seq_state  out  2  current FSM state: INIT=0, RUN=1, MEM_WAIT=2, FLUSH=3.

Function
REQ-015 Outputs SHALL be combinational in seq_state and inputs (Mealy); state, counter and pending flag registered.
REQ-016 INIT: all enables 0, flush_ifid=1, idex_bubble=1; SHALL go to RUN after exactly one cycle.
REQ-017 RUN: default outputs are all enables 1, flush_ifid=0, idex_bubble=0.
REQ-018 Priority within RUN: memory stall > taken branch > load-use.
REQ-019 Memory stall: mem_req=1 and mem_ack=0 SHALL drive all four enables to 0 in the same cycle and move to MEM_WAIT; mem_req with mem_ack=1 in the same cycle causes no stall.
REQ-020 MEM_WAIT: all enables 0, no bubble, no flush; mem_ack=1 SHALL leave for FLUSH if the branch-pending flag is set, otherwise RUN, with enables 1 in the ack cycle.
REQ-021 branch_taken arriving during MEM_WAIT SHALL set the pending flag, which is cleared on entry to FLUSH or by reset.
REQ-022 Taken branch in RUN: pc_en=1, flush_ifid=1, idex_bubble=1 that cycle; load flush counter with FLUSH_CYCLES-1; enter FLUSH if FLUSH_CYCLES>1, else stay in RUN.
REQ-023 FLUSH: pc_en=1, flush_ifid=1, idex_bubble=0; decrement counter each cycle; return to RUN when it reaches 0 (total flush_ifid high = FLUSH_CYCLES cycles).
REQ-024 Memory stall during FLUSH SHALL freeze the counter and all enables until mem_ack, then resume FLUSH.
REQ-025 Load-use: ex_mem_read=1 and ((id_rs1_used and id_rs1==ex_rd) or (id_rs2_used and id_rs2==ex_rd)) SHALL give pc_en=0, ifid_en=0, idex_bubble=1 for exactly that cycle; no state change.
REQ-026 Load-use SHALL be ignored while a taken branch is flushing the ID instruction.

Reset
REQ-027 reset low SHALL asynchronously force seq_state=INIT, counter=0, pending=0; outputs per REQ-016 while held.
REQ-028 Reset mid-MEM_WAIT or mid-FLUSH SHALL discard the operation; no pending branch survives.

Configuration
REQ-029 With HAZARD_SEQ_PERF_EN defined: 16-bit outputs stall_cnt (cycles pc_en=0 outside INIT) and flush_cnt (taken branches accepted), saturating at 16'hFFFF, reset to 0.
REQ-030 Without HAZARD_SEQ_PERF_EN: those ports and counters are absent; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold the seq_state encoding, REG_ADDR_W default, and the 23-bit control-word width constant.
REQ-032 Sub-module hazard_cmp SHALL implement the REQ-025 load-use comparison, combinational only.

Verification
REQ-033 Release reset, idle -> seq_state INIT for 1 cycle then RUN; all enables 1.
REQ-034 ex_mem_read=1, ex_rd=3, id_rs2=3, id_rs2_used=1 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle normal.
REQ-035 branch_taken pulse, FLUSH_CYCLES=2 -> flush_ifid high 2 cycles, idex_bubble high first cycle only, back to RUN.
REQ-036 mem_req=1, mem_ack after 3 cycles, branch_taken pulsed in cycle 2 -> enables 0 for 3 cycles, then FLUSH entered, flush_ifid high 2 cycles.
REQ-037 reset asserted in MEM_WAIT -> immediate INIT, pending cleared, no flush after release beyond INIT.
REQ-038 With HAZARD_SEQ_PERF_EN, 70000 forced stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_seq_pkg.sv
// hazard_seq_pkg: shared state encoding and widths for the hazard sequencer.
package hazard_seq_pkg;
    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2, FLUSH = 2'd3} seq_state_e;
    localparam int REG_ADDR_W_DEF = 3;
    localparam int CTRL_W = 23;
    localparam int CNT_W = 4;
endpackage

// File: rtl/hazard_seq_if.sv
// hazard_seq_if: pipeline <-> hazard sequencer signals; HAZARD_SEQ_PERF_EN adds perf counters.
interface hazard_seq_if import hazard_seq_pkg::*; #(parameter int REG_ADDR_W = REG_ADDR_W_DEF);
    logic ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd, id_rs1, id_rs2;
    logic id_rs1_used, id_rs2_used, branch_taken, mem_req, mem_ack;
    logic pc_en, ifid_en, idex_en, exmem_en, flush_ifid, idex_bubble;
    logic [1:0] seq_state;
`ifdef HAZARD_SEQ_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif
    modport master (
        output ex_mem_read, ex_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used, branch_taken, mem_req, mem_ack,
        input pc_en, ifid_en, idex_en, exmem_en, flush_ifid, idex_bubble, seq_state
`ifdef HAZARD_SEQ_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );
    modport slave (
        input ex_mem_read, ex_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used, branch_taken, mem_req, mem_ack,
        output pc_en, ifid_en, idex_en, exmem_en, flush_ifid, idex_bubble, seq_state
`ifdef HAZARD_SEQ_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use hazard detect between EX load and ID sources.
module hazard_cmp import hazard_seq_pkg::*; #(parameter int REG_ADDR_W = REG_ADDR_W_DEF) (
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    output logic                  hit_o
);
    assign hit_o = ex_mem_read_i & ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                                    (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
endmodule

// File: rtl/hazard_seq.sv
// hazard_seq: pipeline stall/flush sequencer (INIT/RUN/MEM_WAIT/FLUSH), Mealy outputs.
// Define HAZARD_SEQ_PERF_EN to add saturating stall_cnt/flush_cnt counters.
module hazard_seq import hazard_seq_pkg::*; #(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         reset,
    hazard_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] FC    = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] FC_M1 = CNT_W'(FLUSH_CYCLES - 1);
    seq_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d;
    logic [3:0] en;
    logic flush, bubble, accept, load_use, stall;
    hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
        .ex_mem_read_i(bus.ex_mem_read),
        .ex_rd_i(bus.ex_rd),
        .id_rs1_i(bus.id_rs1),
        .id_rs2_i(bus.id_rs2),
        .id_rs1_used_i(bus.id_rs1_used),
        .id_rs2_used_i(bus.id_rs2_used),
        .hit_o(load_use)
    );
    assign stall = bus.mem_req & ~bus.mem_ack;
    // en = {pc, ifid, idex, exmem}
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        pend_d = pend_q;
        en = 4'hF;
        flush = 1'b0;
        bubble = 1'b0;
        accept = 1'b0;
        case (state_q)
            INIT: begin
                en = 4'h0;
                flush = 1'b1;
                bubble = 1'b1;
                state_d = RUN;
            end
            RUN:
                if (stall) begin
                    en = 4'h0;
                    pend_d = bus.branch_taken;
                    state_d = MEM_WAIT;
                end else if (bus.branch_taken) begin
                    flush = 1'b1;
                    bubble = 1'b1;
                    accept = 1'b1;
                    cnt_d = FC_M1;
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (load_use) begin
                    en[3:2] = 2'b00;
                    bubble = 1'b1;
                end
            MEM_WAIT: begin
                pend_d = pend_q | bus.branch_taken;
                if (!bus.mem_ack) en = 4'h0;
                // deferred branch gets a full FLUSH_CYCLES window inside FLUSH
                else if (pend_d) begin
                    pend_d = 1'b0;
                    accept = 1'b1;
                    cnt_d = FC;
                    state_d = FLUSH;
                end else state_d = RUN;
            end
            FLUSH:
                if (stall) en = 4'h0;
                else begin
                    flush = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                    state_d = (cnt_q <= 4'd1) ? RUN : FLUSH;
                end
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= INIT;
            cnt_q <= '0;
            pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pend_q <= pend_d;
        end
    assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en} = en;
    assign bus.flush_ifid = flush;
    assign bus.idex_bubble = bubble;
    assign bus.seq_state = state_q;
`ifdef HAZARD_SEQ_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!en[3] && state_q != INIT && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (accept && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_hazard_seq.sv
// tb_hazard_seq: directed scoreboard bench for hazard_seq (FLUSH_CYCLES=2).
module tb_hazard_seq;
    localparam logic [7:0] INIT_V    = 8'b00_0000_11;
    localparam logic [7:0] RUN_V     = 8'b01_1111_00;
    localparam logic [7:0] LU_V      = 8'b01_0011_01;
    localparam logic [7:0] BR_V      = 8'b01_1111_11;
    localparam logic [7:0] FL_V      = 8'b11_1111_10;
    localparam logic [7:0] STALL_V   = 8'b01_0000_00;
    localparam logic [7:0] MW_V      = 8'b10_0000_00;
    localparam logic [7:0] MW_ACK_V  = 8'b10_1111_00;
    localparam logic [7:0] FL_STL_V  = 8'b11_0000_00;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    logic [7:0] obs;
    hazard_seq_if #(.REG_ADDR_W(3)) bus ();
    hazard_seq #(.REG_ADDR_W(3), .FLUSH_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    // observed vector: {seq_state, pc, ifid, idex, exmem, flush_ifid, idex_bubble}
    assign obs = {bus.seq_state, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.flush_ifid, bus.idex_bubble};
    task automatic cmp(input string tag, input logic [15:0] o);
        logic [15:0] e;
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask
    task automatic chk(input string tag, input logic [7:0] exp);
        sb.push_back({8'h00, exp});
        @(negedge clk);
        cmp(tag, {8'h00, obs});
        @(posedge clk);
        #1;
    endtask
    task automatic chk_now(input string tag, input logic [7:0] exp);
        sb.push_back({8'h00, exp});
        #1;
        cmp(tag, {8'h00, obs});
    endtask
    task automatic lu(input logic on);
        bus.ex_mem_read = on;
        bus.ex_rd = 3'd3;
        bus.id_rs2 = 3'd3;
        bus.id_rs2_used = on;
    endtask
    initial begin
        bus.ex_mem_read = 0; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.branch_taken = 0;
        bus.mem_req = 0; bus.mem_ack = 0;
        @(posedge clk);
        #1;
        chk("reset_hold", INIT_V);
        reset = 1'b1;
        chk("init_one_cycle", INIT_V);
        chk("run_idle", RUN_V);
        lu(1);
        chk("lu_rs2", LU_V);
        lu(0);
        chk("lu_after", RUN_V);
        bus.ex_mem_read = 1; bus.ex_rd = 3'd5; bus.id_rs1 = 3'd5; bus.id_rs1_used = 0;
        chk("lu_rs1_unused", RUN_V);
        bus.id_rs1_used = 1;
        chk("lu_rs1", LU_V);
        bus.ex_mem_read = 0;
        chk("lu_not_load", RUN_V);
        bus.id_rs1_used = 0;
        bus.branch_taken = 1;
        chk("br_c1", BR_V);
        bus.branch_taken = 0;
        chk("br_c2", FL_V);
        chk("br_done", RUN_V);
        bus.branch_taken = 1; lu(1);
        chk("br_lu_c1", BR_V);
        bus.branch_taken = 0;
        chk("br_lu_c2", FL_V);
        lu(0);
        chk("br_lu_done", RUN_V);
        bus.mem_req = 1; bus.mem_ack = 1;
        chk("mem_hit", RUN_V);
        bus.mem_ack = 0;
        chk("mw_c1", STALL_V);
        bus.branch_taken = 1;
        chk("mw_c2", MW_V);
        bus.branch_taken = 0;
        chk("mw_c3", MW_V);
        bus.mem_ack = 1;
        chk("mw_ack", MW_ACK_V);
        bus.mem_req = 0; bus.mem_ack = 0;
        chk("mw_fl1", FL_V);
        chk("mw_fl2", FL_V);
        chk("mw_run", RUN_V);
        bus.mem_req = 1; lu(1);
        chk("mw_over_lu", STALL_V);
        lu(0); bus.mem_ack = 1;
        chk("mw_ack_nopend", MW_ACK_V);
        bus.mem_req = 0; bus.mem_ack = 0;
        chk("mw_nopend_run", RUN_V);
        bus.branch_taken = 1;
        chk("fs_br", BR_V);
        bus.branch_taken = 0; bus.mem_req = 1;
        chk("fs_stall1", FL_STL_V);
        chk("fs_stall2", FL_STL_V);
        bus.mem_ack = 1;
        chk("fs_resume", FL_V);
        bus.mem_req = 0; bus.mem_ack = 0;
        chk("fs_done", RUN_V);
`ifdef HAZARD_SEQ_PERF_EN
        bus.mem_req = 1;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        sb.push_back(16'hFFFF);
        cmp("stall_cnt_sat", bus.stall_cnt);
        sb.push_back(16'd4);
        cmp("flush_cnt", bus.flush_cnt);
        @(posedge clk);
        #1;
        bus.mem_ack = 1;
        chk("perf_ack", MW_ACK_V);
        bus.mem_req = 0; bus.mem_ack = 0;
        chk("perf_run", RUN_V);
`endif
        bus.mem_req = 1;
        chk("rst_mw_c1", STALL_V);
        bus.branch_taken = 1;
        chk("rst_mw_c2", MW_V);
        bus.branch_taken = 0;
        reset = 1'b0;
        chk_now("rst_async", INIT_V);
        chk("rst_held", INIT_V);
        bus.mem_req = 0;
        reset = 1'b1;
        chk("rst_init", INIT_V);
        chk("rst_run1", RUN_V);
        chk("rst_run2", RUN_V);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
